// File: rtl/lowpass_pkg.sv
// Shared definitions for the lowpass post-processor: fixed-point defaults,
// accumulator sizing, FSM encoding and the Butterworth coefficient table.
package lowpass_pkg;

    localparam int LP_FXP_SIZE = 16;
    localparam int LP_FXP_FRAC = 12;
    localparam int LP_STAGES   = 2;
    localparam int LP_COEF_W   = 16;
    localparam int LP_TAPS     = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        WB   = 2'd2
    } lp_state_t;

    function automatic int lp_acc_width(input int fxp_size);
        return 2 * fxp_size + 4;
    endfunction

    // Q4.12 coefficients {b0, b1, b2, a1, a2}; each section has sum(b) == 1 + a1 + a2,
    // so the DC gain is exactly unity and a constant input settles without residue.
    function automatic logic signed [LP_COEF_W-1:0] lp_coef(input int sec, input int tap);
        logic signed [LP_COEF_W-1:0] c;
        c = '0;
        if (sec % 2 == 0) begin
            case (tap)
                0:       c = 16'sd914;
                1:       c = 16'sd1829;
                2:       c = 16'sd914;
                3:       c = -16'sd623;
                4:       c = 16'sd184;
                default: c = '0;
            endcase
        end else begin
            case (tap)
                0:       c = 16'sd1269;
                1:       c = 16'sd2539;
                2:       c = 16'sd1269;
                3:       c = -16'sd865;
                4:       c = 16'sd1846;
                default: c = '0;
            endcase
        end
        return c;
    endfunction

endpackage

// File: rtl/lowpass_mac.sv
// Time-shared multiply-accumulate with round-half-up requantisation of the section output.
// POSTPROCESS_LOWPASS_SAT_EN selects saturation; otherwise the result wraps.
module lowpass_mac
    import lowpass_pkg::*;
#(
    parameter int FXP_SIZE = LP_FXP_SIZE,
    parameter int FXP_FRAC = LP_FXP_FRAC,
    parameter int ACC_W    = lp_acc_width(LP_FXP_SIZE)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en,
    input  logic                        first,
    input  logic                        sub,
    input  logic signed [FXP_SIZE-1:0]  operand,
    input  logic signed [LP_COEF_W-1:0] coef,
    output logic signed [FXP_SIZE-1:0]  y
);

    localparam int PROD_W = FXP_SIZE + LP_COEF_W;
    localparam logic signed [ACC_W-1:0] HALF =
        {{(ACC_W-FXP_FRAC){1'b0}}, 1'b1, {(FXP_FRAC-1){1'b0}}};

    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  prod_ext;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  rnd;
    logic signed [ACC_W-1:0]  shifted;

    assign prod     = PROD_W'(operand) * PROD_W'(coef);
    assign prod_ext = ACC_W'(prod);

    // The first tap of a section overwrites rather than adds, so no separate clear cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc <= '0;
        end else if (en) begin
            acc <= (first ? '0 : acc) + (sub ? -prod_ext : prod_ext);
        end
    end

    assign rnd     = acc + HALF;
    assign shifted = rnd >>> FXP_FRAC;

`ifdef POSTPROCESS_LOWPASS_SAT_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX =
        {{(ACC_W-FXP_SIZE+1){1'b0}}, {(FXP_SIZE-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

    always_comb begin
        y = shifted[FXP_SIZE-1:0];
        if (shifted > SAT_MAX) begin
            y = SAT_MAX[FXP_SIZE-1:0];
        end else if (shifted < SAT_MIN) begin
            y = SAT_MIN[FXP_SIZE-1:0];
        end
    end
`else
    logic unused_hi;
    assign y         = shifted[FXP_SIZE-1:0];
    assign unused_hi = ^shifted[ACC_W-1:FXP_SIZE];
`endif

endmodule

// File: rtl/postprocess_lowpass.sv
// Cascaded direct-form-I biquad lowpass sharing one MAC; optional POSTPROCESS_LOWPASS_SAT_EN.
//   IDLE | waiting for a sample      MAC | 5 taps of current section      WB | requantise, shift history
module postprocess_lowpass
    import lowpass_pkg::*;
#(
    parameter int FXP_SIZE = LP_FXP_SIZE,
    parameter int FXP_FRAC = LP_FXP_FRAC,
    parameter int STAGES   = LP_STAGES
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_valid,
    input  logic [FXP_SIZE-1:0] i_sample,
    output logic                o_valid,
    output logic [FXP_SIZE-1:0] o_sample,
    output logic                o_busy,
    output logic                o_overrun
);

    localparam int SEC_W = (STAGES > 1) ? $clog2(STAGES) : 1;
    localparam logic [SEC_W-1:0] LAST_SEC = SEC_W'(STAGES - 1);
    localparam logic [2:0]       LAST_TAP = 3'(LP_TAPS - 1);

    lp_state_t                  state;
    logic [2:0]                 tap;
    logic [SEC_W-1:0]           sec;
    logic signed [FXP_SIZE-1:0] cur_x;
    logic signed [FXP_SIZE-1:0] x1 [STAGES];
    logic signed [FXP_SIZE-1:0] x2 [STAGES];
    logic signed [FXP_SIZE-1:0] y1 [STAGES];
    logic signed [FXP_SIZE-1:0] y2 [STAGES];

    logic signed [FXP_SIZE-1:0]  operand;
    logic signed [LP_COEF_W-1:0] coef;
    logic signed [FXP_SIZE-1:0]  y_sec;

    always_comb begin
        operand = cur_x;
        case (tap)
            3'd1:    operand = x1[sec];
            3'd2:    operand = x2[sec];
            3'd3:    operand = y1[sec];
            3'd4:    operand = y2[sec];
            default: operand = cur_x;
        endcase
    end

    assign coef   = lp_coef(int'(sec), int'(tap));
    assign o_busy = (state != IDLE);

    lowpass_mac #(
        .FXP_SIZE (FXP_SIZE),
        .FXP_FRAC (FXP_FRAC),
        .ACC_W    (lp_acc_width(FXP_SIZE))
    ) u_mac (
        .clk     (clk),
        .rst     (rst),
        .en      (state == MAC),
        .first   (tap == 3'd0),
        .sub     (tap >= 3'd3),
        .operand (operand),
        .coef    (coef),
        .y       (y_sec)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            tap       <= '0;
            sec       <= '0;
            cur_x     <= '0;
            o_valid   <= 1'b0;
            o_sample  <= '0;
            o_overrun <= 1'b0;
            for (int i = 0; i < STAGES; i++) begin
                x1[i] <= '0;
                x2[i] <= '0;
                y1[i] <= '0;
                y2[i] <= '0;
            end
        end else begin
            o_valid <= 1'b0;
            // A sample arriving mid-computation is discarded without touching history.
            if (i_valid && state != IDLE) begin
                o_overrun <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (i_valid) begin
                        cur_x <= i_sample;
                        sec   <= '0;
                        tap   <= '0;
                        state <= MAC;
                    end
                end
                MAC: begin
                    if (tap == LAST_TAP) begin
                        tap   <= '0;
                        state <= WB;
                    end else begin
                        tap <= tap + 3'd1;
                    end
                end
                WB: begin
                    x2[sec] <= x1[sec];
                    x1[sec] <= cur_x;
                    y2[sec] <= y1[sec];
                    y1[sec] <= y_sec;
                    cur_x   <= y_sec;
                    if (sec == LAST_SEC) begin
                        sec      <= '0;
                        o_valid  <= 1'b1;
                        o_sample <= y_sec;
                        state    <= IDLE;
                    end else begin
                        sec   <= sec + 1'b1;
                        state <= MAC;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_postprocess_lowpass.sv
// Scoreboarded bench for postprocess_lowpass against an arithmetic biquad-cascade model.
module tb_postprocess_lowpass;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        i_valid = 1'b0;
    logic [15:0] i_sample = '0;
    logic        o_valid;
    logic [15:0] o_sample;
    logic        o_busy;
    logic        o_overrun;

    int checks = 0;
    int failures = 0;
    int exp_q[$];
    int last_out = 0;
    int fresh_out = 0;

    int coef_tab [2][5] = '{'{914, 1829, 914, -623, 184},
                            '{1269, 2539, 1269, -865, 1846}};
    int m_x1 [2];
    int m_x2 [2];
    int m_y1 [2];
    int m_y2 [2];

    postprocess_lowpass #(
        .FXP_SIZE (16),
        .FXP_FRAC (12),
        .STAGES   (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .i_valid   (i_valid),
        .i_sample  (i_sample),
        .o_valid   (o_valid),
        .o_sample  (o_sample),
        .o_busy    (o_busy),
        .o_overrun (o_overrun)
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        for (int s = 0; s < 2; s++) begin
            m_x1[s] = 0; m_x2[s] = 0; m_y1[s] = 0; m_y2[s] = 0;
        end
    endfunction

    function automatic int fit16(input int v);
        logic signed [15:0] t;
`ifdef POSTPROCESS_LOWPASS_SAT_EN
        if (v > 32767) v = 32767;
        if (v < -32768) v = -32768;
`endif
        t = v[15:0];
        return int'(t);
    endfunction

    // y = b0*x + b1*x1 + b2*x2 - a1*y1 - a2*y2, rounded by floor((acc + 0.5 LSB) / 2^12)
    function automatic int model_step(input int x);
        int     v;
        int     y;
        longint acc;
        v = x;
        for (int s = 0; s < 2; s++) begin
            acc = longint'(coef_tab[s][0]) * v + longint'(coef_tab[s][1]) * m_x1[s]
                + longint'(coef_tab[s][2]) * m_x2[s] - longint'(coef_tab[s][3]) * m_y1[s]
                - longint'(coef_tab[s][4]) * m_y2[s];
            y = int'((acc + 64'sd2048) >>> 12);
            y = fit16(y);
            m_x2[s] = m_x1[s]; m_x1[s] = v;
            m_y2[s] = m_y1[s]; m_y1[s] = y;
            v = y;
        end
        return v;
    endfunction

    task automatic check(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (o_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_valid actual=%0d expected=no_output at %0t",
                         $signed(o_sample), $time);
            end else begin
                check("scoreboard_sample", $signed(o_sample), exp_q.pop_front());
            end
            last_out = int'($signed(o_sample));
        end
    end

    task automatic send(input logic [15:0] s, input bit track);
        int guard;
        guard = 0;
        while (o_busy !== 1'b0 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) begin
            checks++;
            failures++;
            $display("FAIL busy_timeout actual=busy expected=idle at %0t", $time);
        end
        i_valid  = 1'b1;
        i_sample = s;
        if (track) exp_q.push_back(model_step(int'($signed(s))));
        @(negedge clk);
        i_valid = 1'b0;
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (exp_q.size() != 0 && g < 100) begin
            @(negedge clk);
            g++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout actual=%0d expected=0 pending", exp_q.size());
            exp_q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        model_reset();
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int got;
        logic [15:0] r;
        model_reset();

        // Reset held with i_valid toggling
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            i_valid  = (i % 2 == 0);
            i_sample = 16'h1000;
            check("rst_valid", 32'(o_valid), 0);
            check("rst_sample", $signed(o_sample), 0);
            check("rst_overrun", 32'(o_overrun), 0);
            check("rst_busy", 32'(o_busy), 0);
        end
        i_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Latency of one sample: busy k+1..k+12, valid at k+13
        send(16'h1000, 1'b1);
        for (int n = 1; n <= 13; n++) begin
            if (n > 1) @(negedge clk);
            check($sformatf("lat_busy_%0d", n), 32'(o_busy), (n <= 12) ? 1 : 0);
            check($sformatf("lat_valid_%0d", n), 32'(o_valid), (n == 13) ? 1 : 0);
            if (n == 13) fresh_out = int'($signed(o_sample));
        end
        @(negedge clk);
        check("valid_one_cycle", 32'(o_valid), 0);
        check("sample_hold", $signed(o_sample), fresh_out);

        // Impulse tail, back-to-back acceptance
        for (int i = 0; i < 15; i++) send(16'h0000, 1'b1);
        drain();

        // Random samples with random gaps
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 1) == 1) r = 16'($urandom_range(0, 8191) - 4096);
            else r = 16'($urandom_range(0, 65535));
            repeat ($urandom_range(0, 3)) @(negedge clk);
            send(r, 1'b1);
        end
        drain();

        // Overrun: second sample at k+5 is dropped and flag sticks
        do_reset();
        check("overrun_after_reset", 32'(o_overrun), 0);
        send(16'h1000, 1'b1);
        repeat (4) @(negedge clk);
        i_valid  = 1'b1;
        i_sample = 16'h7FFF;
        @(negedge clk);
        i_valid = 1'b0;
        check("overrun_set", 32'(o_overrun), 1);
        drain();
        check("overrun_first_out", last_out, fresh_out);
        for (int i = 0; i < 5; i++) send(16'h0000, 1'b1);
        drain();
        check("overrun_sticky", 32'(o_overrun), 1);

        // Reset mid-computation aborts without a pulse
        send(16'h0123, 1'b0);
        repeat (5) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        check("abort_busy", 32'(o_busy), 0);
        check("abort_overrun_cleared", 32'(o_overrun), 0);
        repeat (20) @(negedge clk);
        send(16'h1000, 1'b1);
        got = 0;
        for (int n = 0; n < 20 && got == 0; n++) begin
            if (o_valid === 1'b1) begin
                got = 1;
                check("abort_next_out", $signed(o_sample), fresh_out);
            end else begin
                @(negedge clk);
            end
        end
        if (got == 0) begin
            checks++;
            failures++;
            $display("FAIL abort_next_timeout actual=no_valid expected=valid");
        end
        drain();

        // Full-scale alternating step
        do_reset();
        for (int i = 0; i < 24; i++) send((i % 2 == 0) ? 16'h7FFF : 16'h8000, 1'b1);
        drain();

        // DC settling
        do_reset();
        for (int i = 0; i < 200; i++) send(16'h1000, 1'b1);
        drain();
        checks++;
        if (last_out < 4094 || last_out > 4098) begin
            failures++;
            $display("FAIL dc_final actual=%0d expected=4096+/-2", last_out);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/postprocess_lowpass.md
POSTPROCESS_LOWPASS -- requirements
Module: postprocess_lowpass

Interface
REQ-001 SHALL have parameter FXP_SIZE, default 16: sample word width, two's complement.
REQ-002 SHALL have parameter FXP_FRAC, default 12: fractional bits of samples and coefficients.
REQ-003 SHALL have parameter STAGES, default 2: number of cascaded biquad sections (4th-order lowpass).
REQ-004 SHALL have port clk, input, 1: single clock; all logic on rising edge.
REQ-005 SHALL have port rst, input, 1: asynchronous reset, active-low (asserted at 0).
REQ-006 SHALL have port i_valid, input, 1: i_sample is valid this cycle.
REQ-007 SHALL have port i_sample, input, FXP_SIZE: input sample, Q(FXP_SIZE-FXP_FRAC).FXP_FRAC.
REQ-008 SHALL have port o_valid, output, 1: one-cycle pulse; o_sample is valid.
REQ-009 SHALL have port o_sample, output, FXP_SIZE: filtered sample, same format as i_sample.
REQ-010 SHALL have port o_busy, output, 1: high while a sample is being processed.
REQ-011 SHALL have port o_overrun, output, 1: sticky flag; a sample was dropped.

Function
REQ-012 SHALL implement each section as direct-form-I biquad: y = b0*x + b1*x1 + b2*x2 - a1*y1 - a2*y2, using one time-shared multiplier-accumulator.
REQ-013 SHALL use FSM states IDLE, MAC, WB: IDLE->MAC on accepted sample; MAC runs tap counter 0..4 (5 cycles); MAC->WB; WB->MAC for next section, or WB->IDLE after last section.
REQ-014 SHALL accept i_sample only when i_valid=1 in IDLE.
REQ-015 SHALL make o_busy=1 exactly when state is not IDLE.
REQ-016 SHALL drop any sample presented with i_valid=1 while o_busy=1, set o_overrun, and leave filter state unaffected.
REQ-017 SHALL assert o_valid for one cycle, STAGES*6+1 cycles after acceptance (13 for STAGES=2), with a new sample acceptable in that same cycle.
REQ-018 SHALL hold o_sample stable between o_valid pulses.
REQ-019 SHALL use an accumulator of 2*FXP_SIZE+4 bits and round-half-up when shifting right by FXP_FRAC in WB.
REQ-020 SHALL, in WB, shift that section's x2<=x1, x1<=x, y2<=y1, y1<=y_rounded, and pass y_rounded as the next section's x.
REQ-021 SHALL clear o_overrun only on reset.

Reset
REQ-022 SHALL, while rst=0, force state IDLE, tap counter 0, all x/y history to 0, accumulator 0, o_sample 0, o_valid 0, o_overrun 0.
REQ-023 SHALL abort any in-progress computation on reset, with no o_valid pulse for the aborted sample.

Configuration
REQ-024 SHALL, with POSTPROCESS_LOWPASS_SAT_EN defined, saturate each rounded section output to [-2^(FXP_SIZE-1), 2^(FXP_SIZE-1)-1].
REQ-025 SHALL, without POSTPROCESS_LOWPASS_SAT_EN, truncate each rounded section output to FXP_SIZE bits (two's-complement wrap).

Structure
REQ-026 SHALL take FXP_SIZE/FXP_FRAC defaults, accumulator width, FSM state enum, and coefficient table (STAGES x 5, Butterworth 10 kHz at 44.1 kHz, per-section DC gain 1.0) from shared package lowpass_pkg.
REQ-027 SHALL place the multiplier, accumulator and rounding/saturation in sub-module lowpass_mac; the FSM and history storage stay in the top.

Verification
REQ-028 SHALL verify reset: hold rst=0 for 5 cycles with i_valid toggling -> o_valid=0, o_sample=0x0000, o_overrun=0, o_busy=0.
REQ-029 SHALL verify latency: single sample 0x1000 accepted at cycle k -> o_busy high k+1..k+12, o_valid high only at k+13.
REQ-030 SHALL verify DC: 200 samples of 0x1000 spaced 13 cycles -> final o_sample within 0x1000 +/-2 LSB; impulse 0x1000 then zeros matches the Python model bit-exactly.
REQ-031 SHALL verify overrun: second i_valid at k+5 -> o_overrun=1 permanently, and output sequence equals the single-sample case.
REQ-032 SHALL verify saturation: with SAT_EN, a 0x7FFF/0x8000 square wave at 22.05 kHz alternating step -> o_sample never changes sign opposite to the model and never wraps; without SAT_EN -> the wrapped values match the model.
REQ-033 SHALL verify reset mid-operation: rst=0 at k+6 for 1 cycle -> no o_valid; the next sample 0x1000 gives output equal to the first output after a fresh reset.
